// File: rtl/ureg_cell_pkg.sv
// Shared definitions for the ureg_cell universal register: iMode encodings
// (as the library-wide UREG_* defines) and the matching enum type.
`ifndef UREG_HOLD
`define UREG_HOLD 3'b000
`define UREG_LOAD 3'b001
`define UREG_SHL  3'b010
`define UREG_SHR  3'b011
`define UREG_ROTL 3'b100
`define UREG_ROTR 3'b101
`define UREG_INC  3'b110
`define UREG_DEC  3'b111
`endif

package ureg_cell_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = `UREG_HOLD,
    MODE_LOAD = `UREG_LOAD,
    MODE_SHL  = `UREG_SHL,
    MODE_SHR  = `UREG_SHR,
    MODE_ROTL = `UREG_ROTL,
    MODE_ROTR = `UREG_ROTR,
    MODE_INC  = `UREG_INC,
    MODE_DEC  = `UREG_DEC
  } mode_e;

endpackage

// File: rtl/ureg_cell_next.sv
// Combinational next-value and next-carry logic for ureg_cell.
// Build option UREG_SAT_EN: INC/DEC saturate at the ends instead of wrapping.
module ureg_next
  import ureg_cell_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl,
  input  logic             sr,
  output logic [WIDTH-1:0] q_nxt,
  output logic             c_nxt
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // Arithmetic is done one bit wider so the MSB is the carry or borrow.
  logic [WIDTH:0] sum;

  always_comb begin
    q_nxt = q;
    c_nxt = 1'b0;
    sum   = '0;
    case (mode_e'(mode))
      MODE_HOLD: begin
        q_nxt = q;
        c_nxt = 1'b0;
      end
      MODE_LOAD: begin
        q_nxt = d;
        c_nxt = 1'b0;
      end
      MODE_SHL: begin
        q_nxt = {q[WIDTH-2:0], sl};
        c_nxt = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt = {sr, q[WIDTH-1:1]};
        c_nxt = q[0];
      end
      MODE_ROTL: begin
        q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        c_nxt = q[WIDTH-1];
      end
      MODE_ROTR: begin
        q_nxt = {q[0], q[WIDTH-1:1]};
        c_nxt = q[0];
      end
      MODE_INC: begin
        sum   = {1'b0, q} + ONE;
        q_nxt = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
`ifdef UREG_SAT_EN
        if (sum[WIDTH]) q_nxt = q;
`endif
      end
      MODE_DEC: begin
        sum   = {1'b0, q} - ONE;
        q_nxt = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
`ifdef UREG_SAT_EN
        if (sum[WIDTH]) q_nxt = q;
`endif
      end
      default: begin
        q_nxt = q;
        c_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ureg_cell.sv
// Universal WIDTH-bit register: clear > preset > enable priority around the
// ureg_next operation logic. Saturating counting is selected by UREG_SAT_EN.
module ureg_cell
  import ureg_cell_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iPre,
  input  logic             iEnb,
  input  logic [2:0]       iMode,
  input  logic [WIDTH-1:0] iD,
  input  logic             iSL,
  input  logic             iSR,
  output logic [WIDTH-1:0] oQp,
  output logic [WIDTH-1:0] oQn,
  output logic             oCarry
);

  logic [WIDTH-1:0] q_nxt;
  logic             c_nxt;

  ureg_next #(.WIDTH(WIDTH)) u_next (
    .q     (oQp),
    .mode  (iMode),
    .d     (iD),
    .sl    (iSL),
    .sr    (iSR),
    .q_nxt (q_nxt),
    .c_nxt (c_nxt)
  );

  always_ff @(posedge iClk) begin
    if (iClr) begin
      oQp    <= '0;
      oCarry <= 1'b0;
    end else if (iPre) begin
      oQp    <= PRESET_VAL;
      oCarry <= 1'b0;
    end else if (iEnb) begin
      oQp    <= q_nxt;
      oCarry <= c_nxt;
    end
  end

  // Complement is derived combinationally so it can never skew from oQp.
  assign oQn = ~oQp;

endmodule

// File: tb/tb_ureg_cell.sv
// Scoreboard bench for ureg_cell (WIDTH=8): directed plan plus random traffic,
// expected values from an arithmetic reference model; honours UREG_SAT_EN.
module tb_ureg_cell;
  import ureg_cell_pkg::*;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         clr = 1'b1, pre = 1'b0, enb = 1'b0, sl = 1'b0, sr = 1'b0;
  logic [2:0]   mode = `UREG_HOLD;
  logic [W-1:0] d = '0;
  logic [W-1:0] qp, qn;
  logic         carry;

  ureg_cell #(.WIDTH(W)) dut (
    .iClk(clk), .iClr(clr), .iPre(pre), .iEnb(enb), .iMode(mode), .iD(d),
    .iSL(sl), .iSR(sr), .oQp(qp), .oQn(qn), .oCarry(carry)
  );

  always #5 clk = ~clk;

  int exp_q[$];
  int exp_c[$];
  int model_q = 0;
  int model_c = 0;
  int vectors = 0;
  int miscompares = 0;

  // Reference model: applies one clock edge worth of behaviour to model_q/c.
  task automatic model_step(input int c_clr, input int c_pre, input int c_enb,
                            input int c_mode, input int c_d, input int c_sl,
                            input int c_sr);
    int nq, nc;
    nq = model_q;
    nc = model_c;
    if (c_clr != 0) begin
      nq = 0; nc = 0;
    end else if (c_pre != 0) begin
      nq = MOD - 1; nc = 0;
    end else if (c_enb != 0) begin
      case (c_mode)
        0: begin nq = model_q; nc = 0; end
        1: begin nq = c_d; nc = 0; end
        2: begin nq = (model_q * 2 + c_sl) % MOD; nc = model_q / (MOD / 2); end
        3: begin nq = model_q / 2 + c_sr * (MOD / 2); nc = model_q % 2; end
        4: begin nq = (model_q * 2) % MOD + model_q / (MOD / 2); nc = model_q / (MOD / 2); end
        5: begin nq = model_q / 2 + (model_q % 2) * (MOD / 2); nc = model_q % 2; end
        6: begin
          if (model_q == MOD - 1) begin
`ifdef UREG_SAT_EN
            nq = MOD - 1;
`else
            nq = 0;
`endif
            nc = 1;
          end else begin
            nq = model_q + 1; nc = 0;
          end
        end
        default: begin
          if (model_q == 0) begin
`ifdef UREG_SAT_EN
            nq = 0;
`else
            nq = MOD - 1;
`endif
            nc = 1;
          end else begin
            nq = model_q - 1; nc = 0;
          end
        end
      endcase
    end
    model_q = nq;
    model_c = nc;
  endtask

  task automatic apply(input int c_clr, input int c_pre, input int c_enb,
                       input int c_mode, input int c_d, input int c_sl,
                       input int c_sr);
    @(negedge clk);
    clr  = (c_clr != 0);
    pre  = (c_pre != 0);
    enb  = (c_enb != 0);
    mode = 3'(c_mode);
    d    = W'(c_d);
    sl   = (c_sl != 0);
    sr   = (c_sr != 0);
    model_step(c_clr, c_pre, c_enb, c_mode, c_d, c_sl, c_sr);
    exp_q.push_back(model_q);
    exp_c.push_back(model_c);
  endtask

  task automatic op(input int c_mode, input int c_d = 0, input int c_sl = 0,
                    input int c_sr = 0);
    apply(0, 0, 1, c_mode, c_d, c_sl, c_sr);
  endtask

  // Monitor: every edge with an outstanding expectation is checked just after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      int eq, ec;
      eq = exp_q.pop_front();
      ec = exp_c.pop_front();
      vectors++;
      if (qp !== W'(eq)) begin
        miscompares++;
        $display("FAIL oQp vector %0d: got %02h expected %02h", vectors, qp, W'(eq));
      end
      if (qn !== W'(~eq)) begin
        miscompares++;
        $display("FAIL oQn vector %0d: got %02h expected %02h", vectors, qn, W'(~eq));
      end
      if (carry !== 1'(ec)) begin
        miscompares++;
        $display("FAIL oCarry vector %0d: got %0b expected %0b", vectors, carry, 1'(ec));
      end
    end
  end

  initial begin
    // Reset/priority: clear beats preset and enable; then preset alone.
    apply(1, 1, 1, `UREG_INC, 0, 0, 0);
    apply(0, 1, 1, `UREG_INC, 0, 0, 0);
    // Load then hold with enable low.
    op(`UREG_LOAD, 8'hA5);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, `UREG_INC, 0, 0, 0);
    // Shift/rotate.
    op(`UREG_SHL, 0, 1, 0);
    op(`UREG_SHR, 0, 0, 0);
    op(`UREG_LOAD, 8'h81);
    op(`UREG_ROTL);
    op(`UREG_ROTR);
    // Count wrap.
    op(`UREG_LOAD, 8'hFE);
    op(`UREG_INC);
    op(`UREG_INC);
    op(`UREG_DEC);
    op(`UREG_DEC);
    // End-of-range counting (saturates when UREG_SAT_EN is defined).
    op(`UREG_LOAD, 8'hFF);
    op(`UREG_INC);
    op(`UREG_LOAD, 8'h00);
    op(`UREG_DEC);
    // Carry held while disabled after a carry-producing op.
    apply(0, 0, 0, `UREG_SHL, 0, 0, 0);
    // Reset mid-run.
    apply(1, 0, 0, `UREG_HOLD, 0, 0, 0);
    for (int i = 0; i < 5; i++) op(`UREG_INC);
    apply(1, 0, 1, `UREG_INC, 0, 0, 0);
    for (int i = 0; i < 4; i++) op(`UREG_INC);
    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      apply(($urandom_range(0, 15) == 0) ? 1 : 0,
            ($urandom_range(0, 15) == 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, MOD - 1)),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)));
    end
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
